// File: rtl/sdlx_pkg.sv
// Shared SDLX definitions: R-type instruction field positions, ALU control
// codes and the opcode/func decoder used by the issue stage.
package sdlx_pkg;

  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 26;
  localparam int RS1_HI  = 25;
  localparam int RS1_LO  = 21;
  localparam int RS2_HI  = 20;
  localparam int RS2_LO  = 16;
  localparam int RD_HI   = 15;
  localparam int RD_LO   = 11;
  localparam int FUNC_HI = 5;
  localparam int FUNC_LO = 0;

  localparam logic [5:0] OP_RTYPE    = 6'd0;
  localparam logic [5:0] ALU_ILLEGAL = 6'd0;

  typedef enum logic [5:0] {
    ALU_ADD = 6'd1,  ALU_SUB = 6'd2,  ALU_AND = 6'd3,  ALU_OR  = 6'd4,
    ALU_XOR = 6'd5,  ALU_SLL = 6'd6,  ALU_SRL = 6'd7,  ALU_SRA = 6'd8,
    ALU_ROL = 6'd9,  ALU_ROR = 6'd10, ALU_SLT = 6'd11, ALU_SGT = 6'd12,
    ALU_SLE = 6'd13, ALU_SGE = 6'd14, ALU_UGT = 6'd15, ALU_ULT = 6'd16,
    ALU_ULE = 6'd17, ALU_UGE = 6'd18
  } alu_ctrl_e;

  // func maps one-to-one onto the ALU code; anything else decodes to 0.
  function automatic logic [5:0] alu_decode(input logic [5:0] opcode, input logic [5:0] func);
    if (opcode == OP_RTYPE && func >= ALU_ADD && func <= ALU_UGE)
      return func;
    return ALU_ILLEGAL;
  endfunction

endpackage

// File: rtl/sdlx_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, r0 hardwired to zero, synchronous reset of every register.
module sdlx_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] word [32];

  assign word[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_reg
      logic [31:0] reg_q;
      // Reset has priority, so write-back during rst is dropped.
      always_ff @(posedge clk) begin
        if (rst)
          reg_q <= '0;
        else if (we_i && waddr_i == 5'(gi))
          reg_q <= wdata_i;
      end
      assign word[gi] = reg_q;
    end
  endgenerate

  assign rdata1_o = word[raddr1_i];
  assign rdata2_o = word[raddr2_i];

endmodule

// File: rtl/sdlx_rtype_issue.sv
// Decode-and-issue stage for SDLX R-type instructions: decode, operand read
// with write-back forwarding, pending-destination scoreboard, output register.
module sdlx_rtype_issue
  import sdlx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_A,
  output logic [31:0] out_B,
  output logic [5:0]  out_ALU_ctrl,
  output logic [4:0]  out_rd,
  output logic        out_illegal,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [5:0]  opcode, func, ctrl;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rf_a, rf_b, op_a, op_b;
  logic [31:0] clr_mask, set_mask, pend_live;
  logic [31:0] pend_q, pend_d;
  logic        hazard, accept, legal;
  logic        unused_shamt;
  logic [0:0]  state_q, state_d;
  logic [31:0] a_q, b_q;
  logic [5:0]  ctrl_q;
  logic [4:0]  rd_q;
  logic        ill_q;

  assign opcode       = in_instr[OPC_HI:OPC_LO];
  assign rs1          = in_instr[RS1_HI:RS1_LO];
  assign rs2          = in_instr[RS2_HI:RS2_LO];
  assign rd           = in_instr[RD_HI:RD_LO];
  assign func         = in_instr[FUNC_HI:FUNC_LO];
  assign unused_shamt = ^in_instr[10:6];

  sdlx_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rf_a),
    .rdata2_o (rf_b),
    .we_i     (wb_en),
    .waddr_i  (wb_rd),
    .wdata_i  (wb_data)
  );

  assign op_a = (wb_en && wb_rd == rs1 && rs1 != 5'd0) ? wb_data : rf_a;
  assign op_b = (wb_en && wb_rd == rs2 && rs2 != 5'd0) ? wb_data : rf_b;

  // A register being written back this cycle no longer blocks issue.
  assign clr_mask  = wb_en ? (32'd1 << wb_rd) : '0;
  assign pend_live = pend_q & ~clr_mask;
  assign hazard    = pend_live[rs1] | pend_live[rs2] | pend_live[rd];

  assign ctrl     = alu_decode(opcode, func);
  assign legal    = (ctrl != ALU_ILLEGAL);
  assign in_ready = !rst && !hazard && (state_q == S_EMPTY || out_ready);
  assign accept   = in_valid && in_ready;

  // Set is OR-ed in after the clear so it wins on the same bit; r0 never pends.
  assign set_mask = (accept && legal) ? (32'd1 << rd) : '0;
  assign pend_d   = (pend_live | set_mask) & 32'hFFFF_FFFE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = S_FULL;
      S_FULL:  if (out_ready && !accept) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      pend_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      rd_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (accept) begin
        a_q    <= op_a;
        b_q    <= op_b;
        ctrl_q <= ctrl;
        rd_q   <= rd;
        ill_q  <= !legal;
      end
    end
  end

  assign out_valid    = (state_q == S_FULL);
  assign out_A        = a_q;
  assign out_B        = b_q;
  assign out_ALU_ctrl = ctrl_q;
  assign out_rd       = rd_q;
  assign out_illegal  = ill_q;

endmodule

// File: tb/tb_sdlx_rtype_issue.sv
// Scoreboard bench for sdlx_rtype_issue: a cycle-level reference model
// predicts in_ready/out_valid and queues expected issues for the monitor.
module tb_sdlx_rtype_issue;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic        wb_en;
  logic [31:0] in_instr, out_A, out_B, wb_data;
  logic [5:0]  out_ALU_ctrl;
  logic [4:0]  out_rd, wb_rd;

  sdlx_rtype_issue dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_A        (out_A),
    .out_B        (out_B),
    .out_ALU_ctrl (out_ALU_ctrl),
    .out_rd       (out_rd),
    .out_illegal  (out_illegal),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  ctrl;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  bit          m_full = 1'b0;
  int          n_issued = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int s1, input int s2, input int d, input int fn);
    return {op[5:0], s1[4:0], s2[4:0], d[4:0], 5'd0, fn[5:0]};
  endfunction

  // Reference model: evaluated mid-cycle on stable inputs, then advanced
  // as the coming rising edge will.
  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
      for (int r = 0; r < 32; r++) begin
        m_regs[r] = '0;
        m_pend[r] = 1'b0;
      end
      m_full = 1'b0;
      exp_q.delete();
    end else begin
      int  s1, s2, d, op, fn;
      bit  haz, rdy, acc, legal;
      exp_t e;
      op = int'(in_instr[31:26]);
      s1 = int'(in_instr[25:21]);
      s2 = int'(in_instr[20:16]);
      d  = int'(in_instr[15:11]);
      fn = int'(in_instr[5:0]);
      haz = (m_pend[s1] && !(wb_en && int'(wb_rd) == s1)) ||
            (m_pend[s2] && !(wb_en && int'(wb_rd) == s2)) ||
            (m_pend[d]  && !(wb_en && int'(wb_rd) == d));
      rdy = !haz && (!m_full || out_ready);
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
      chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
      acc   = in_valid && rdy;
      legal = (op == 0) && (fn >= 1) && (fn <= 18);
      if (acc) begin
        e.a    = (s1 == 0) ? 32'd0 : (wb_en && int'(wb_rd) == s1) ? wb_data : m_regs[s1];
        e.b    = (s2 == 0) ? 32'd0 : (wb_en && int'(wb_rd) == s2) ? wb_data : m_regs[s2];
        e.ctrl = legal ? fn[5:0] : 6'd0;
        e.rd   = d[4:0];
        e.ill  = !legal;
        exp_q.push_back(e);
        n_issued++;
      end
      if (wb_en) begin
        if (wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
        m_pend[wb_rd] = 1'b0;
      end
      if (acc && legal && d != 0) m_pend[d] = 1'b1;
      if (acc) m_full = 1'b1;
      else if (out_ready) m_full = 1'b0;
    end
  end

  // Monitor: compares whatever the DUT presents against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        chk("out_A", out_A, exp_q[0].a);
        chk("out_B", out_B, exp_q[0].b);
        chk("out_ALU_ctrl", {26'd0, out_ALU_ctrl}, {26'd0, exp_q[0].ctrl});
        chk("out_rd", {27'd0, out_rd}, {27'd0, exp_q[0].rd});
        chk("out_illegal", {31'd0, out_illegal}, {31'd0, exp_q[0].ill});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input bit we,
                       input int wr, input logic [31:0] wd, input bit ordy);
    in_valid  = v;
    in_instr  = ins;
    wb_en     = we;
    wb_rd     = wr[4:0];
    wb_data   = wd;
    out_ready = ordy;
    step();
  endtask

  task automatic drain();
    for (int r = 1; r < 32; r++)
      if (m_pend[r]) drive(1'b0, '0, 1'b1, r, $urandom, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_instr = '0; wb_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_A", out_A, 32'd0);
    chk("rst_out_B", out_B, 32'd0);
    chk("rst_out_ctrl", {26'd0, out_ALU_ctrl}, 32'd0);
    chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
    chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
    @(posedge clk); #1;

    // Preload, ADD r3,r1,r2, then SUB r4,r3,r1 stalled until r3 writes back.
    drive(1'b0, '0, 1'b1, 1, 32'd5, 1'b1);
    drive(1'b0, '0, 1'b1, 2, 32'd7, 1'b1);
    drive(1'b1, mk(0, 1, 2, 3, 1), 1'b0, 0, '0, 1'b1);
    drive(1'b1, mk(0, 3, 1, 4, 2), 1'b0, 0, '0, 1'b1);
    drive(1'b1, mk(0, 3, 1, 4, 2), 1'b0, 0, '0, 1'b1);
    drive(1'b1, mk(0, 3, 1, 4, 2), 1'b1, 3, 32'd12, 1'b1);
    drive(1'b0, '0, 1'b1, 4, 32'd7, 1'b1);

    // Illegal opcode / func, each followed by a legal write of the same rd.
    drive(1'b1, mk(8, 1, 2, 5, 1), 1'b0, 0, '0, 1'b1);
    drive(1'b1, mk(0, 1, 2, 5, 3), 1'b0, 0, '0, 1'b1);
    drive(1'b1, mk(0, 2, 1, 6, 19), 1'b1, 5, 32'hAAAA_0001, 1'b1);
    drive(1'b1, mk(0, 2, 1, 6, 18), 1'b0, 0, '0, 1'b1);
    drain();

    // Back-pressure for four cycles, then back-to-back accept on release.
    drive(1'b1, mk(0, 1, 2, 7, 4), 1'b0, 0, '0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, mk(0, 2, 2, 8, 5), 1'b0, 0, '0, 1'b0);
    drive(1'b1, mk(0, 2, 2, 8, 5), 1'b0, 0, '0, 1'b1);
    drive(1'b0, '0, 1'b0, 0, '0, 1'b1);
    drain();

    // r0 stays zero even after a write-back to it.
    drive(1'b0, '0, 1'b1, 0, 32'hFFFF_FFFF, 1'b1);
    drive(1'b1, mk(0, 0, 0, 9, 4), 1'b0, 0, '0, 1'b1);
    drain();

    // Reset with r3 pending and output held, then immediate re-issue.
    drive(1'b1, mk(0, 1, 2, 3, 1), 1'b0, 0, '0, 1'b0);
    rst = 1'b1;
    drive(1'b0, '0, 1'b1, 3, 32'h1234_5678, 1'b0);
    rst = 1'b0;
    drive(1'b1, mk(0, 3, 3, 6, 1), 1'b0, 0, '0, 1'b1);
    drive(1'b0, '0, 1'b0, 0, '0, 1'b1);
    drain();

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 2000; i++) begin
      int op, fn;
      op  = ($urandom_range(0, 9) == 0) ? 8 : 0;
      fn  = $urandom_range(0, 20);
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 3) != 0,
            mk(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), fn),
            $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
            $urandom_range(0, 3) != 0);
    end
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 0, '0, 1'b1);
    drain();
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b0, 0, '0, 1'b1);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    if (n_issued < 100) chk("issue_count_low", n_issued, 32'd100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
